// File: rtl/seq_scan_ctrl.sv
// ============================================================================
// seq_scan_ctrl : serializes a word MSB-first and counts overlapping pattern hits
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_scan_ctrl #(
  parameter int WIDTH   = 16,
  parameter int PAT_LEN = 2,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_word_valid,
  input  logic [WIDTH-1:0]   i_word,
  input  logic [PAT_LEN-1:0] i_pattern,
  output logic               o_word_ready,
  output logic               o_bit,
  output logic               o_bit_valid,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_count_valid,
  input  logic               i_count_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_first_hit = CNT_W'(PAT_LEN - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   word_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PAT_LEN-1:0] hist_d;
  logic               match_d;

  // The word register shifts left, so its MSB is always the next bit to emit.
  generate
    if (PAT_LEN == 1) begin : g_hist_single
      assign hist_d = word_q[WIDTH-1];
    end else begin : g_hist_multi
      assign hist_d = {hist_q[PAT_LEN-2:0], word_q[WIDTH-1]};
    end
  endgenerate

  assign match_d      = (idx_q >= c_first_hit) && (hist_d == pat_q);
  assign o_word_ready = (state_q == S_IDLE);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      pat_q         <= '0;
      hist_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      o_bit         <= 1'b0;
      o_bit_valid   <= 1'b0;
      o_match       <= 1'b0;
      o_count       <= '0;
      o_count_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          o_bit         <= 1'b0;
          o_bit_valid   <= 1'b0;
          o_match       <= 1'b0;
          o_count_valid <= 1'b0;
          if (i_word_valid) begin
            word_q  <= i_word;
            pat_q   <= i_pattern;
            hist_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            o_count <= '0;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (idx_q == c_last_idx) begin
            o_bit         <= 1'b0;
            o_bit_valid   <= 1'b0;
            o_match       <= 1'b0;
            o_count       <= cnt_q;
            o_count_valid <= 1'b1;
            state_q       <= S_REPORT;
          end else begin
            o_bit       <= word_q[WIDTH-1];
            o_bit_valid <= 1'b1;
            o_match     <= match_d;
            hist_q      <= hist_d;
            word_q      <= word_q << 1;
            cnt_q       <= cnt_q + CNT_W'(match_d);
            idx_q       <= idx_q + CNT_W'(1);
          end
        end

        S_REPORT: begin
          // o_count stays put here and afterwards until the next word is taken.
          if (i_count_ready) begin
            o_count_valid <= 1'b0;
            state_q       <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// ============================================================================
// tb_seq_scan_ctrl : directed scoreboard bench for seq_scan_ctrl (WIDTH=8, PAT_LEN=2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_scan_ctrl;

  localparam int WIDTH   = 8;
  localparam int PAT_LEN = 2;
  localparam int CNT_W   = 4;

  logic               clk;
  logic               i_reset_n;
  logic               i_word_valid;
  logic [WIDTH-1:0]   i_word;
  logic [PAT_LEN-1:0] i_pattern;
  logic               o_word_ready;
  logic               o_bit;
  logic               o_bit_valid;
  logic               o_match;
  logic [CNT_W-1:0]   o_count;
  logic               o_count_valid;
  logic               i_count_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic             exp_bit_q[$];
  logic             exp_match_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];

  seq_scan_ctrl #(.WIDTH(WIDTH), .PAT_LEN(PAT_LEN)) dut (
    .i_clock       (clk),
    .i_reset_n     (i_reset_n),
    .i_word_valid  (i_word_valid),
    .i_word        (i_word),
    .i_pattern     (i_pattern),
    .o_word_ready  (o_word_ready),
    .o_bit         (o_bit),
    .o_bit_valid   (o_bit_valid),
    .o_match       (o_match),
    .o_count       (o_count),
    .o_count_valid (o_count_valid),
    .i_count_ready (i_count_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected bits/matches when o_bit_valid, expected count on handshake.
  always @(negedge clk) begin
    if (i_reset_n) begin
      if (o_bit_valid) begin
        if (exp_bit_q.size() == 0) begin
          chk("unexpected_bit_valid", 32'(o_bit_valid), 32'(0));
        end else begin
          chk("o_bit", 32'(o_bit), 32'(exp_bit_q.pop_front()));
          chk("o_match", 32'(o_match), 32'(exp_match_q.pop_front()));
        end
      end else begin
        chk("match_without_bit", 32'(o_match), 32'(0));
      end
      if (o_count_valid) begin
        chk("ready_in_report", 32'(o_word_ready), 32'(0));
        if (exp_cnt_q.size() == 0) begin
          chk("unexpected_count_valid", 32'(o_count_valid), 32'(0));
        end else begin
          chk("o_count", 32'(o_count), 32'(exp_cnt_q[0]));
          if (i_count_ready) void'(exp_cnt_q.pop_front());
        end
      end
    end
  end

  task automatic push_expect(input logic [7:0] w, input logic [7:0] mask, input logic [3:0] cnt);
    for (int b = 7; b >= 0; b--) begin
      exp_bit_q.push_back(w[b]);
      exp_match_q.push_back(mask[b]);
    end
    exp_cnt_q.push_back(cnt);
  endtask

  // Called mid-cycle; returns #1 after the acceptance edge (cycle 0).
  task automatic accept(input logic [7:0] w, input logic [1:0] p);
    bit ok = 0;
    i_word_valid = 1'b1;
    i_word       = w;
    i_pattern    = p;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (o_word_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    i_word_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  // From cycle 0 (+#1) through the first IDLE cycle (no backpressure).
  task automatic track(input bit change, input logic [7:0] w, input logic [1:0] p);
    if (change) begin
      i_pattern = ~p;
      i_word    = ~w;
    end
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c == 0) chk("bit_valid_c0", 32'(o_bit_valid), 32'(0));
      if (c == 1) chk("bit_valid_c1", 32'(o_bit_valid), 32'(1));
      if (c == 8) chk("count_valid_c8", 32'(o_count_valid), 32'(0));
      if (c == 9) begin
        chk("count_valid_c9", 32'(o_count_valid), 32'(1));
        chk("bit_valid_c9", 32'(o_bit_valid), 32'(0));
      end
    end
    @(negedge clk);
    chk("idle_ready_c10", 32'(o_word_ready), 32'(1));
    chk("count_valid_c10", 32'(o_count_valid), 32'(0));
    chk("bits_drained", 32'(exp_bit_q.size()), 32'(0));
    chk("counts_drained", 32'(exp_cnt_q.size()), 32'(0));
  endtask

  task automatic run_word(input logic [7:0] w, input logic [1:0] p, input logic [7:0] mask,
                          input logic [3:0] cnt, input bit change);
    push_expect(w, mask, cnt);
    accept(w, p);
    track(change, w, p);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_word_ready"}, 32'(o_word_ready), 32'(1));
    chk({tag, "_bit"}, 32'(o_bit), 32'(0));
    chk({tag, "_bit_valid"}, 32'(o_bit_valid), 32'(0));
    chk({tag, "_match"}, 32'(o_match), 32'(0));
    chk({tag, "_count"}, 32'(o_count), 32'(0));
    chk({tag, "_count_valid"}, 32'(o_count_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n     = 1'b0;
    i_word_valid  = 1'b0;
    i_word        = '0;
    i_pattern     = '0;
    i_count_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 i_reset_n = 1'b1;

    // Test 1: pattern 10 over 1011_0010 -> hits at cycles 2,5,8
    run_word(8'b1011_0010, 2'b10, 8'b0100_1001, 4'd3, 1'b0);
    // Test 2: overlapping 11 over FF -> hits at cycles 2..8
    run_word(8'hFF, 2'b11, 8'b0111_1111, 4'd7, 1'b0);
    // Test 3: no hits, count 0 still reported
    run_word(8'h00, 2'b10, 8'h00, 4'd0, 1'b0);

    // Test 4: backpressure with the next word already offered
    i_count_ready = 1'b0;
    push_expect(8'b1101_1011, 8'b0100_1001, 4'd3);
    accept(8'b1101_1011, 2'b11);
    push_expect(8'b0110_0110, 8'b0100_0100, 4'd2);
    i_word_valid = 1'b1;
    i_word       = 8'b0110_0110;
    i_pattern    = 2'b01;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 9) begin
        chk("bp_count_valid", 32'(o_count_valid), 32'(1));
        chk("bp_count_stable", 32'(o_count), 32'(3));
        chk("bp_word_ready", 32'(o_word_ready), 32'(0));
      end
    end
    @(posedge clk);
    #1 i_count_ready = 1'b1;
    @(negedge clk);
    chk("bp_c14_ready", 32'(o_word_ready), 32'(0));
    @(negedge clk);
    chk("bp_c15_ready", 32'(o_word_ready), 32'(1));
    chk("bp_c15_count_valid", 32'(o_count_valid), 32'(0));
    chk("bp_c15_count_hold", 32'(o_count), 32'(3));
    @(posedge clk);
    #1 i_word_valid = 1'b0;
    chk("bp_next_accepted", 32'(o_word_ready), 32'(0));
    track(1'b0, 8'b0110_0110, 2'b01);

    // Test 5: reset asserted in cycle 4, then a fresh word sees no stale history
    push_expect(8'b1011_0010, 8'b0100_1001, 4'd3);
    accept(8'b1011_0010, 2'b10);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    i_word_valid = 1'b1;
    i_reset_n    = 1'b0;
    @(posedge clk);
    #1;
    i_reset_n    = 1'b1;
    i_word_valid = 1'b0;
    exp_bit_q.delete();
    exp_match_q.delete();
    exp_cnt_q.delete();
    @(negedge clk);
    chk_reset_vals("midreset");
    run_word(8'b1000_0000, 2'b10, 8'b0100_0000, 4'd1, 1'b0);

    // Test 6: pattern and word changed while the word is in flight
    run_word(8'b1011_0010, 2'b10, 8'b0100_1001, 4'd3, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
